// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
// MEM_STAGE_BYTE_ACCESS_EN enables byte loads/stores in mem_stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [3:0] BE_WORD = 4'hF;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // Byte-enable for a single-byte access on the given lane.
    function automatic logic [3:0] byte_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner: picks a byte lane and extends it, or passes the word.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic        is_byte_i,
    input  logic        is_unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0] sel_c;

    always_comb begin
        sel_c  = 8'h00;
        data_o = word_i;
        case (lane_i)
            LANE0:   sel_c = word_i[7:0];
            LANE1:   sel_c = word_i[15:8];
            LANE2:   sel_c = word_i[23:16];
            LANE3:   sel_c = word_i[31:24];
            default: sel_c = 8'h00;
        endcase
        if (is_byte_i) begin
            data_o = is_unsigned_i ? {24'h000000, sel_c} : {{24{sel_c[7]}}, sel_c};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU results pass through, loads/stores go to data memory.
// Define MEM_STAGE_BYTE_ACCESS_EN to enable byte-granular loads and stores.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              is_load_in,
    input  logic              is_store_in,
    input  logic              is_write_in,
    input  logic              is_byte_in,
    input  logic              is_unsigned_in,
    input  logic [4:0]        rd_in,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_be,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_write,
    output logic              misalign
);

    state_e            state_q, state_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_write_q, wb_write_d;
    logic              misalign_q, misalign_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [3:0]        req_be_q, req_be_d;
    logic              req_we_q, req_we_d;
    logic [4:0]        rd_q, rd_d;
    logic              write_q, write_d;
    logic              byte_q, byte_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        lane_q, lane_d;

    logic              byte_c;
    logic              unsigned_c;
    logic              mem_op_c;
    logic              misaligned_c;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [31:0]       load_data_c;

`ifdef MEM_STAGE_BYTE_ACCESS_EN
    assign byte_c     = is_byte_in;
    assign unsigned_c = is_unsigned_in;
    assign be_c       = is_byte_in ? byte_be(alu_result[1:0]) : BE_WORD;
    assign wdata_c    = is_byte_in ? {4{store_data[7:0]}} : store_data;
`else
    logic unused_byte_c;
    assign unused_byte_c = ^{is_byte_in, is_unsigned_in};
    assign byte_c        = 1'b0;
    assign unsigned_c    = 1'b0;
    assign be_c          = BE_WORD;
    assign wdata_c       = store_data;
`endif

    assign mem_op_c     = is_load_in | is_store_in;
    assign misaligned_c = mem_op_c && !byte_c && (alu_result[1:0] != 2'b00);

    load_align u_load_align (
        .word_i        (mem_resp_data),
        .lane_i        (lane_q),
        .is_byte_i     (byte_q),
        .is_unsigned_i (unsigned_q),
        .data_o        (load_data_c)
    );

    // State and pipeline registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wb_valid_q  <= 1'b0;
            wb_write_q  <= 1'b0;
            misalign_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            req_we_q    <= 1'b0;
            rd_q        <= '0;
            write_q     <= 1'b0;
            byte_q      <= 1'b0;
            unsigned_q  <= 1'b0;
            lane_q      <= '0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_write_q  <= wb_write_d;
            misalign_q  <= misalign_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            req_we_q    <= req_we_d;
            rd_q        <= rd_d;
            write_q     <= write_d;
            byte_q      <= byte_d;
            unsigned_q  <= unsigned_d;
            lane_q      <= lane_d;
        end
    end

    // Next-state and write-back decode.
    always_comb begin
        state_d     = state_q;
        wb_valid_d  = 1'b0;
        wb_write_d  = 1'b0;
        misalign_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        req_we_d    = req_we_q;
        rd_d        = rd_q;
        write_d     = write_q;
        byte_d      = byte_q;
        unsigned_d  = unsigned_q;
        lane_d      = lane_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rd_d        = rd_in;
                    write_d     = is_write_in;
                    byte_d      = byte_c;
                    unsigned_d  = unsigned_c;
                    lane_d      = alu_result[1:0];
                    req_addr_d  = ADDR_W'(alu_result);
                    req_wdata_d = wdata_c;
                    req_be_d    = be_c;
                    req_we_d    = is_store_in;
                    if (misaligned_c) begin
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                        wb_data_d  = DATA_W'(alu_result);
                        wb_rd_d    = rd_in;
                    end else if (mem_op_c) begin
                        state_d = REQ;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_write_d = is_write_in;
                        wb_data_d  = DATA_W'(alu_result);
                        wb_rd_d    = rd_in;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    if (req_we_q) begin
                        state_d    = IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_write_d = write_q;
                    wb_data_d  = DATA_W'(load_data_c);
                    wb_rd_d    = rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready      = (state_q == IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_be    = req_be_q;
    assign wb_valid      = wb_valid_q;
    assign wb_write      = wb_write_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign misalign      = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; byte-access vectors run when
// MEM_STAGE_BYTE_ACCESS_EN is defined.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        is_load_in, is_store_in, is_write_in, is_byte_in, is_unsigned_in;
    logic [4:0]  rd_in;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        wb_valid, wb_write, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .is_load_in     (is_load_in),
        .is_store_in    (is_store_in),
        .is_write_in    (is_write_in),
        .is_byte_in     (is_byte_in),
        .is_unsigned_in (is_unsigned_in),
        .rd_in          (rd_in),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_be     (mem_req_be),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_write       (wb_write),
        .misalign       (misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid       = 1'b0;
        alu_result     = 32'h0;
        store_data     = 32'h0;
        is_load_in     = 1'b0;
        is_store_in    = 1'b0;
        is_write_in    = 1'b0;
        is_byte_in     = 1'b0;
        is_unsigned_in = 1'b0;
        rd_in          = 5'd0;
    endtask

    // Present one instruction for a single cycle.
    task automatic issue(input logic [31:0] addr, input logic [31:0] sdata, input logic ld,
                         input logic st, input logic wr, input logic byt, input logic uns,
                         input logic [4:0] rd);
        in_valid       = 1'b1;
        alu_result     = addr;
        store_data     = sdata;
        is_load_in     = ld;
        is_store_in    = st;
        is_write_in    = wr;
        is_byte_in     = byt;
        is_unsigned_in = uns;
        rd_in          = rd;
        step();
        idle_inputs();
    endtask

    // Load with immediate request handshake and a response the following cycle.
    task automatic load_now(input string tag, input logic [31:0] addr, input logic uns,
                            input logic byt, input logic [31:0] resp, input logic [31:0] exp);
        mem_req_ready = 1'b1;
        issue(addr, 32'h0, 1'b1, 1'b0, 1'b1, byt, uns, 5'd9);
        check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = resp;
        step();
        mem_resp_valid = 1'b0;
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_wb_data"}, wb_data, exp);
        step();
    endtask

    initial begin
        idle_inputs();
        rst            = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        step();
        step();
        rst = 1'b1;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_req_addr", mem_req_addr, 32'h0);

        // Back-to-back ALU ops
        in_valid = 1'b1; alu_result = 32'h11; is_write_in = 1'b1; rd_in = 5'd3;
        step();
        check("alu0_valid", 32'(wb_valid), 32'd1);
        check("alu0_data", wb_data, 32'h11);
        check("alu0_rd", 32'(wb_rd), 32'd3);
        check("alu0_write", 32'(wb_write), 32'd1);
        check("alu0_ready", 32'(in_ready), 32'd1);
        alu_result = 32'h22; rd_in = 5'd4; is_write_in = 1'b0;
        step();
        idle_inputs();
        check("alu1_valid", 32'(wb_valid), 32'd1);
        check("alu1_data", wb_data, 32'h22);
        check("alu1_rd", 32'(wb_rd), 32'd4);
        check("alu1_write", 32'(wb_write), 32'd0);
        step();
        check("alu_pulse", 32'(wb_valid), 32'd0);

        // Word store with mem_req_ready held low for 3 cycles
        issue(32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
        for (int i = 0; i < 3; i++) begin
            check("st_req_valid", 32'(mem_req_valid), 32'd1);
            check("st_addr", mem_req_addr, 32'h100);
            check("st_we", 32'(mem_req_we), 32'd1);
            check("st_wdata", mem_req_wdata, 32'hDEADBEEF);
            check("st_be", 32'(mem_req_be), 32'hF);
            check("st_ready_low", 32'(in_ready), 32'd0);
            check("st_no_wb", 32'(wb_valid), 32'd0);
            step();
        end
        mem_req_ready = 1'b1;
        check("st_req_hs", 32'(mem_req_valid), 32'd1);
        step();
        mem_req_ready = 1'b0;
        check("st_wb_valid", 32'(wb_valid), 32'd1);
        check("st_wb_write", 32'(wb_write), 32'd0);
        check("st_req_drop", 32'(mem_req_valid), 32'd0);
        check("st_in_ready", 32'(in_ready), 32'd1);
        step();
        check("st_pulse", 32'(wb_valid), 32'd0);

        // Word load, response 4 cycles after the handshake
        mem_req_ready = 1'b1;
        issue(32'h104, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7);
        check("ld_req_valid", 32'(mem_req_valid), 32'd1);
        check("ld_addr", mem_req_addr, 32'h104);
        check("ld_we", 32'(mem_req_we), 32'd0);
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_ready", 32'(in_ready), 32'd0);
            check("ld_wait_req", 32'(mem_req_valid), 32'd0);
            check("ld_wait_wb", 32'(wb_valid), 32'd0);
            step();
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hCAFEF00D;
        check("ld_resp_ready", 32'(in_ready), 32'd0);
        step();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        check("ld_wb_valid", 32'(wb_valid), 32'd1);
        check("ld_wb_data", wb_data, 32'hCAFEF00D);
        check("ld_wb_rd", 32'(wb_rd), 32'd7);
        check("ld_wb_write", 32'(wb_write), 32'd1);
        check("ld_in_ready", 32'(in_ready), 32'd1);
        step();
        check("ld_pulse", 32'(wb_valid), 32'd0);

        // Misaligned word load
        issue(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
        check("mis_no_req", 32'(mem_req_valid), 32'd0);
        check("mis_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_wb_write", 32'(wb_write), 32'd0);
        check("mis_in_ready", 32'(in_ready), 32'd1);
        step();
        check("mis_pulse", 32'(misalign), 32'd0);

        // Stray response while idle is ignored
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h12345678;
        step();
        mem_resp_valid = 1'b0;
        check("stray_no_wb", 32'(wb_valid), 32'd0);
        check("stray_req", 32'(mem_req_valid), 32'd0);

`ifdef MEM_STAGE_BYTE_ACCESS_EN
        load_now("lb_signed", 32'h103, 1'b0, 1'b1, 32'h80123456, 32'hFFFFFF80);
        load_now("lb_unsigned", 32'h103, 1'b1, 1'b1, 32'h80123456, 32'h00000080);
        issue(32'h101, 32'h0000005A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        check("sb_req_valid", 32'(mem_req_valid), 32'd1);
        check("sb_be", 32'(mem_req_be), 32'h2);
        check("sb_wdata", mem_req_wdata, 32'h5A5A5A5A);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("sb_wb_valid", 32'(wb_valid), 32'd1);
        step();
`else
        // Byte flags are ignored: a "byte" load at 0x103 is a misaligned word access
        issue(32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1);
        check("nb_no_req", 32'(mem_req_valid), 32'd0);
        check("nb_misalign", 32'(misalign), 32'd1);
        step();
        load_now("nb_word", 32'h108, 1'b1, 1'b0, 32'h80123456, 32'h80123456);
`endif

        // Reset while waiting for a load response
        mem_req_ready = 1'b1;
        issue(32'h200, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6);
        step();
        mem_req_ready = 1'b0;
        check("rw_in_wait", 32'(in_ready), 32'd0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rw_in_ready", 32'(in_ready), 32'd1);
        check("rw_req_valid", 32'(mem_req_valid), 32'd0);
        check("rw_wb_valid", 32'(wb_valid), 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hABCD0123;
        step();
        mem_resp_valid = 1'b0;
        check("rw_late_resp", 32'(wb_valid), 32'd0);
        check("rw_still_idle", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
